// File: rtl/ysyx_050518_wb_unit_if.sv
// rtl/ysyx_050518_wb_unit_if.sv - write-back unit bus: ALU/LSU results, issue marking, hazard query, regfile write port
interface ysyx_050518_wb_unit_if #(
  parameter int XLEN = 64
);
  logic            alu_valid;
  logic [4:0]      alu_rd_addr;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd_addr;
  logic [XLEN-1:0] lsu_data;
  logic            issue_en;
  logic [4:0]      issue_rd;
  logic [4:0]      q_rs1_addr;
  logic [4:0]      q_rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rs1_fwd_valid;
  logic            rs2_fwd_valid;
  logic [XLEN-1:0] fwd_data1;
  logic [XLEN-1:0] fwd_data2;
  logic            write_en;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd;

  // Write-back unit side
  modport slave (
    input  alu_valid, alu_rd_addr, alu_data,
    input  lsu_valid, lsu_rd_addr, lsu_data,
    output lsu_ready,
    input  issue_en, issue_rd, q_rs1_addr, q_rs2_addr,
    output rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid, fwd_data1, fwd_data2,
    output write_en, rd_addr, rd
  );

  // Producer / consumer side (EXU, LSU, issue stage, register file)
  modport master (
    output alu_valid, alu_rd_addr, alu_data,
    output lsu_valid, lsu_rd_addr, lsu_data,
    input  lsu_ready,
    output issue_en, issue_rd, q_rs1_addr, q_rs2_addr,
    input  rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid, fwd_data1, fwd_data2,
    input  write_en, rd_addr, rd
  );
endinterface

// File: rtl/ysyx_050518_wb_unit.sv
// rtl/ysyx_050518_wb_unit.sv - write-back merge of ALU/LSU results with pending scoreboard; optional bypass via YSYX_050518_WB_BYPASS_EN
module ysyx_050518_wb_unit #(
  parameter int XLEN     = 64,
  parameter int LQ_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ysyx_050518_wb_unit_if.slave     bus
);

  localparam int        PW      = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam logic [PW:0] LQ_FULL = (PW+1)'(LQ_DEPTH);

  logic [4:0]      r_q_addr [LQ_DEPTH];
  logic [XLEN-1:0] r_q_data [LQ_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;

  logic            r_write_en;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rd;
  logic [31:0]     r_pending;

  logic            w_full;
  logic            w_enq;
  logic            w_deq;
  logic            w_sel;
  logic [4:0]      w_sel_addr;
  logic [XLEN-1:0] w_sel_data;
  logic [31:0]     w_pending_nxt;
  logic            w_fwd1;
  logic            w_fwd2;

  // Ready depends on occupancy only, so a full queue refuses even on a dequeue cycle.
  assign w_full        = (r_count == LQ_FULL);
  assign bus.lsu_ready = !w_full;
  assign w_enq         = bus.lsu_valid & !w_full;
  assign w_deq         = !bus.alu_valid & (r_count != '0);

  // ALU has absolute priority; queue head is taken only when the ALU is idle.
  always_comb begin
    w_sel      = 1'b0;
    w_sel_addr = r_rd_addr;
    w_sel_data = r_rd;
    if (bus.alu_valid) begin
      w_sel      = 1'b1;
      w_sel_addr = bus.alu_rd_addr;
      w_sel_data = bus.alu_data;
    end else if (w_deq) begin
      w_sel      = 1'b1;
      w_sel_addr = r_q_addr[r_head];
      w_sel_data = r_q_data[r_head];
    end
  end

  // Queue storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_addr[r_tail] <= bus.lsu_rd_addr;
      r_q_data[r_tail] <= bus.lsu_data;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PW'(1);
      if (w_deq) r_head <= r_head + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Register-file write port; x0 results are consumed without a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_en <= 1'b0;
      r_rd_addr  <= '0;
      r_rd       <= '0;
    end else begin
      r_write_en <= w_sel & (w_sel_addr != 5'd0);
      r_rd_addr  <= w_sel_addr;
      r_rd       <= w_sel_data;
    end
  end

  assign bus.write_en = r_write_en;
  assign bus.rd_addr  = r_rd_addr;
  assign bus.rd       = r_rd;

  // Scoreboard update: clear on the completing write, then a new issue to the same register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_write_en) w_pending_nxt[r_rd_addr] = 1'b0;
    if (bus.issue_en && bus.issue_rd != 5'd0) w_pending_nxt[bus.issue_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard state; cleared asynchronously so busy drops the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

`ifdef YSYX_050518_WB_BYPASS_EN
  assign w_fwd1        = r_write_en & (r_rd_addr == bus.q_rs1_addr) & (bus.q_rs1_addr != 5'd0);
  assign w_fwd2        = r_write_en & (r_rd_addr == bus.q_rs2_addr) & (bus.q_rs2_addr != 5'd0);
  assign bus.fwd_data1 = r_rd;
  assign bus.fwd_data2 = r_rd;
`else
  assign w_fwd1        = 1'b0;
  assign w_fwd2        = 1'b0;
  assign bus.fwd_data1 = '0;
  assign bus.fwd_data2 = '0;
`endif

  assign bus.rs1_fwd_valid = w_fwd1;
  assign bus.rs2_fwd_valid = w_fwd2;
  // A forwarded value satisfies the consumer, so it no longer needs to stall.
  assign bus.rs1_busy      = r_pending[bus.q_rs1_addr] & !w_fwd1;
  assign bus.rs2_busy      = r_pending[bus.q_rs2_addr] & !w_fwd2;

endmodule

// File: tb/tb_ysyx_050518_wb_unit.sv
// tb/tb_ysyx_050518_wb_unit.sv - directed self-checking bench for ysyx_050518_wb_unit
module tb_ysyx_050518_wb_unit;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  logic acc;

  ysyx_050518_wb_unit_if #(.XLEN(64)) wb ();

  ysyx_050518_wb_unit #(.XLEN(64), .LQ_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wb.alu_valid   = 1'b0;
    wb.alu_rd_addr = '0;
    wb.alu_data    = '0;
    wb.lsu_valid   = 1'b0;
    wb.lsu_rd_addr = '0;
    wb.lsu_data    = '0;
    wb.issue_en    = 1'b0;
    wb.issue_rd    = '0;
    wb.q_rs1_addr  = '0;
    wb.q_rs2_addr  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    idle();
    rst_n = 1'b0;
    #23;
    chk("rst_write_en", wb.write_en, 0);
    chk("rst_rd_addr", wb.rd_addr, 0);
    chk("rst_rd", wb.rd, 0);
    chk("rst_lsu_ready", wb.lsu_ready, 1);
    wb.q_rs1_addr = 5'd7;
    #1;
    chk("rst_rs1_busy", wb.rs1_busy, 0);
    chk("rst_rs1_fwd", wb.rs1_fwd_valid, 0);
    rst_n = 1'b1;
    tick();

    // ALU single write and latency
    wb.alu_valid = 1'b1; wb.alu_rd_addr = 5'd5; wb.alu_data = 64'hDEAD;
    tick();
    wb.alu_valid = 1'b0;
    #1;
    chk("alu_we", wb.write_en, 1);
    chk("alu_addr", wb.rd_addr, 5);
    chk("alu_data", wb.rd, 64'hDEAD);
    tick();
    chk("alu_we_drop", wb.write_en, 0);
    chk("alu_addr_hold", wb.rd_addr, 5);

    // Scoreboard on register 7
    wb.issue_en = 1'b1; wb.issue_rd = 5'd7; wb.q_rs1_addr = 5'd7; wb.q_rs2_addr = 5'd0;
    tick();
    wb.issue_en = 1'b0;
    #1;
    chk("sb_busy_set", wb.rs1_busy, 1);
    chk("sb_busy_x0", wb.rs2_busy, 0);
    wb.alu_valid = 1'b1; wb.alu_rd_addr = 5'd7; wb.alu_data = 64'h77;
    #1;
    chk("sb_busy_before_write", wb.rs1_busy, 1);
    tick();
    wb.alu_valid = 1'b0;
    #1;
    chk("sb_write_we", wb.write_en, 1);
`ifdef YSYX_050518_WB_BYPASS_EN
    chk("sb_busy_write_cycle", wb.rs1_busy, 0);
    chk("sb_fwd_valid", wb.rs1_fwd_valid, 1);
    chk("sb_fwd_data", wb.fwd_data1, 64'h77);
`else
    chk("sb_busy_write_cycle", wb.rs1_busy, 1);
    chk("sb_fwd_valid", wb.rs1_fwd_valid, 0);
    chk("sb_fwd_data", wb.fwd_data1, 0);
`endif
    tick();
    chk("sb_busy_cleared", wb.rs1_busy, 0);
    chk("sb_fwd_after", wb.rs1_fwd_valid, 0);

    // Five LSU results while the ALU monopolises the port
    wb.alu_valid = 1'b1; wb.alu_rd_addr = 5'd1; wb.alu_data = 64'h100;
    wb.lsu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb.lsu_rd_addr = 5'(10 + i); wb.lsu_data = 64'h1000 + 64'(i);
      #1;
      chk($sformatf("lq_ready_%0d", i), wb.lsu_ready, 1);
      tick();
    end
    wb.lsu_rd_addr = 5'd14; wb.lsu_data = 64'h1004;
    #1;
    chk("lq_full_ready", wb.lsu_ready, 0);
    chk("lq_alu_we", wb.write_en, 1);
    chk("lq_alu_addr", wb.rd_addr, 1);
    tick();
    chk("lq_still_full", wb.lsu_ready, 0);
    wb.alu_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      acc = wb.lsu_valid & wb.lsu_ready;
      tick();
      if (acc) wb.lsu_valid = 1'b0;
      #1;
      chk($sformatf("lq_drain_we_%0d", k), wb.write_en, 1);
      chk($sformatf("lq_drain_addr_%0d", k), wb.rd_addr, 64'(10 + k));
      chk($sformatf("lq_drain_data_%0d", k), wb.rd, 64'h1000 + 64'(k));
    end
    tick();
    chk("lq_drain_done_we", wb.write_en, 0);
    chk("lq_drain_done_ready", wb.lsu_ready, 1);

    // ALU and queue head competing in the same cycle
    wb.lsu_valid = 1'b1; wb.lsu_rd_addr = 5'd4; wb.lsu_data = 64'h44;
    tick();
    wb.lsu_valid = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_rd_addr = 5'd3; wb.alu_data = 64'h33;
    tick();
    wb.alu_valid = 1'b0;
    #1;
    chk("arb_first_addr", wb.rd_addr, 3);
    chk("arb_first_data", wb.rd, 64'h33);
    tick();
    chk("arb_second_we", wb.write_en, 1);
    chk("arb_second_addr", wb.rd_addr, 4);
    chk("arb_second_data", wb.rd, 64'h44);
    tick();
    chk("arb_idle_we", wb.write_en, 0);

    // Results to x0
    wb.alu_valid = 1'b1; wb.alu_rd_addr = 5'd0; wb.alu_data = 64'hBAD;
    tick();
    wb.alu_valid = 1'b0;
    #1;
    chk("x0_alu_we", wb.write_en, 0);
    chk("x0_alu_data", wb.rd, 64'hBAD);
    wb.lsu_valid = 1'b1; wb.lsu_rd_addr = 5'd0; wb.lsu_data = 64'hBEEF;
    wb.issue_en = 1'b1; wb.issue_rd = 5'd0; wb.q_rs1_addr = 5'd0;
    tick();
    wb.lsu_valid = 1'b0; wb.issue_en = 1'b0;
    #1;
    chk("x0_busy", wb.rs1_busy, 0);
    tick();
    chk("x0_lsu_we", wb.write_en, 0);
    chk("x0_lsu_data", wb.rd, 64'hBEEF);
    tick();
    chk("x0_lsu_empty_we", wb.write_en, 0);
    chk("x0_lsu_ready", wb.lsu_ready, 1);

    // Reset during a drain with a full queue and pending bits set
    wb.alu_valid = 1'b1; wb.alu_rd_addr = 5'd2; wb.alu_data = 64'h2;
    wb.lsu_valid = 1'b1; wb.issue_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb.lsu_rd_addr = 5'(20 + i); wb.lsu_data = 64'h2000 + 64'(i);
      wb.issue_rd = 5'(20 + i);
      tick();
    end
    wb.lsu_valid = 1'b0; wb.issue_en = 1'b0; wb.alu_valid = 1'b0;
    wb.q_rs1_addr = 5'd21; wb.q_rs2_addr = 5'd22;
    #1;
    chk("rm_full", wb.lsu_ready, 0);
    chk("rm_busy_pre", wb.rs1_busy, 1);
    tick();
    chk("rm_drain_we", wb.write_en, 1);
    chk("rm_drain_addr", wb.rd_addr, 20);
    rst_n = 1'b0;
    #1;
    chk("rm_we", wb.write_en, 0);
    chk("rm_ready", wb.lsu_ready, 1);
    chk("rm_busy1", wb.rs1_busy, 0);
    chk("rm_busy2", wb.rs2_busy, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rm_quiet_%0d", k), wb.write_en, 0);
    end
    chk("rm_ready_after", wb.lsu_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
